br_resolve_ctrl: RTL and testbench

- Branch-resolution controller for the EX stage of the 5-stage RV32I pipeline.
- Sequences the branch comparator: drives its unsigned and SLTI-select controls, and evaluates its less/equal flags against funct3.
- Compares the resolved outcome with the fetch-time prediction and issues redirect/flush on mispredict.
- Owns the branch history table (BHT) of 2-bit saturating counters that supplies IF-stage predictions, plus saturating branch/mispredict statistics counters.

---
 rtl/br_resolve_ctrl_pkg.sv | 37 +++
 rtl/br_resolve_ctrl_bht_table.sv | 34 +++
 rtl/br_resolve_ctrl.sv | 105 ++++++++++
 tb/tb_br_resolve_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/br_resolve_ctrl_pkg.sv
// Shared EX-stage branch definitions: funct3 encodings and BHT counter states.
// Also provides the saturating update rule used by the branch history table.
package br_resolve_ctrl_pkg;

    localparam logic [2:0] F3_BEQ   = 3'b000;
    localparam logic [2:0] F3_BNE   = 3'b001;
    localparam logic [2:0] F3_SLTIU = 3'b011;
    localparam logic [2:0] F3_BLT   = 3'b100;
    localparam logic [2:0] F3_BGE   = 3'b101;
    localparam logic [2:0] F3_BLTU  = 3'b110;
    localparam logic [2:0] F3_BGEU  = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_e;

    function automatic bht_state_e bht_next(input bht_state_e s, input logic taken);
        bht_state_e n;
        n = s;
        unique case (s)
            SNT: n = taken ? WNT : SNT;
            WNT: n = taken ? WT  : SNT;
            WT:  n = taken ? ST  : WNT;
            ST:  n = taken ? ST  : WT;
            default: n = WNT;
        endcase
        return n;
    endfunction

    function automatic logic bht_pred(input bht_state_e s);
        return (s == WT) || (s == ST);
    endfunction

endpackage

// File: rtl/br_resolve_ctrl_bht_table.sv
// Branch history table: 2-bit saturating counters, async-read lookup port,
// single write port applying the saturating update on the stored state.
module bht_table
    import br_resolve_ctrl_pkg::*;
#(
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output bht_state_e       rd_state,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    localparam int unsigned ENTRIES = 1 << IDX_W;

    bht_state_e entry_q [ENTRIES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                entry_q[i] <= WNT;
            end
        end else if (wr_en) begin
            entry_q[wr_idx] <= bht_next(entry_q[wr_idx], wr_taken);
        end
    end

    // Read sees the registered value only; a same-cycle write lands next cycle.
    assign rd_state = entry_q[rd_idx];

endmodule

// File: rtl/br_resolve_ctrl.sv
// EX-stage branch resolution: comparator control, outcome decode, mispredict
// redirect/flush, BHT training and saturating branch statistics.
module br_resolve_ctrl
    import br_resolve_ctrl_pkg::*;
#(
    parameter int unsigned BHT_IDX_W = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [31:0]      i_pc_f,
    output logic             o_pred_taken_f,
    input  logic             i_valid_e,
    input  logic             i_branch_e,
    input  logic             i_slti_e,
    input  logic [2:0]       i_funct3_e,
    input  logic [31:0]      i_pc_e,
    input  logic             i_pred_taken_e,
    input  logic             i_stall_e,
    input  logic             i_br_less,
    input  logic             i_br_equal,
    output logic             o_br_un,
    output logic             o_slti_sel,
    output logic             o_taken_e,
    output logic             o_redirect,
    output logic             o_redirect_tgt,
    output logic             o_flush_fd,
    output logic             o_flush_de,
    output logic [CNT_W-1:0] o_branch_cnt,
    output logic [CNT_W-1:0] o_mispred_cnt
);

    logic       active;
    logic       update;
    logic       mispredict;
    logic       taken;
    bht_state_e lookup_state;
    logic       unused_pc;

    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] mispred_cnt_q;

    assign active = i_valid_e & i_branch_e;
    assign update = active & ~i_stall_e;

    assign o_slti_sel = i_slti_e;
    assign o_br_un    = (i_branch_e & ((i_funct3_e == F3_BLTU) | (i_funct3_e == F3_BGEU)))
                      | (i_slti_e & (i_funct3_e == F3_SLTIU));

    always_comb begin
        taken = 1'b0;
        if (active) begin
            case (i_funct3_e)
                F3_BEQ:           taken = i_br_equal;
                F3_BNE:           taken = ~i_br_equal;
                F3_BLT, F3_BLTU:  taken = i_br_less;
                F3_BGE, F3_BGEU:  taken = ~i_br_less;
                default:          taken = 1'b0;
            endcase
        end
    end

    assign o_taken_e  = taken;
    assign mispredict = update & (taken != i_pred_taken_e);

    assign o_redirect     = mispredict;
    assign o_flush_fd     = mispredict;
    assign o_flush_de     = mispredict;
    assign o_redirect_tgt = taken;

    bht_table #(
        .IDX_W (BHT_IDX_W)
    ) u_bht (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .rd_idx   (i_pc_f[BHT_IDX_W+1:2]),
        .rd_state (lookup_state),
        .wr_en    (update),
        .wr_idx   (i_pc_e[BHT_IDX_W+1:2]),
        .wr_taken (taken)
    );

    assign o_pred_taken_f = bht_pred(lookup_state);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else if (update) begin
            if (branch_cnt_q != '1) begin
                branch_cnt_q <= branch_cnt_q + 1'b1;
            end
            if (mispredict && (mispred_cnt_q != '1)) begin
                mispred_cnt_q <= mispred_cnt_q + 1'b1;
            end
        end
    end

    assign o_branch_cnt  = branch_cnt_q;
    assign o_mispred_cnt = mispred_cnt_q;

    assign unused_pc = ^{i_pc_f[31:BHT_IDX_W+2], i_pc_f[1:0],
                         i_pc_e[31:BHT_IDX_W+2], i_pc_e[1:0]};

endmodule

// File: tb/tb_br_resolve_ctrl.sv
// Directed self-checking bench for br_resolve_ctrl (counters narrowed to 4 bits
// so saturation is reachable in a short run).
module tb_br_resolve_ctrl;

    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst_n;
    logic [31:0]   pc_f;
    logic          pred_taken_f;
    logic          valid_e;
    logic          branch_e;
    logic          slti_e;
    logic [2:0]    funct3_e;
    logic [31:0]   pc_e;
    logic          pred_taken_e;
    logic          stall_e;
    logic          br_less;
    logic          br_equal;
    logic          br_un;
    logic          slti_sel;
    logic          taken_e;
    logic          redirect;
    logic          redirect_tgt;
    logic          flush_fd;
    logic          flush_de;
    logic [CW-1:0] branch_cnt;
    logic [CW-1:0] mispred_cnt;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned exp_br = 0;
    int unsigned exp_mis = 0;

    br_resolve_ctrl #(
        .BHT_IDX_W (4),
        .CNT_W     (CW)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_pc_f         (pc_f),
        .o_pred_taken_f (pred_taken_f),
        .i_valid_e      (valid_e),
        .i_branch_e     (branch_e),
        .i_slti_e       (slti_e),
        .i_funct3_e     (funct3_e),
        .i_pc_e         (pc_e),
        .i_pred_taken_e (pred_taken_e),
        .i_stall_e      (stall_e),
        .i_br_less      (br_less),
        .i_br_equal     (br_equal),
        .o_br_un        (br_un),
        .o_slti_sel     (slti_sel),
        .o_taken_e      (taken_e),
        .o_redirect     (redirect),
        .o_redirect_tgt (redirect_tgt),
        .o_flush_fd     (flush_fd),
        .o_flush_de     (flush_de),
        .o_branch_cnt   (branch_cnt),
        .o_mispred_cnt  (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_e = 1'b0; branch_e = 1'b0; slti_e = 1'b0; stall_e = 1'b0;
        funct3_e = 3'b000; br_less = 1'b0; br_equal = 1'b0; pred_taken_e = 1'b0;
    endtask

    task automatic set_br(input logic [2:0] f3, input logic less, input logic eq,
                          input logic pred, input logic [31:0] pc);
        valid_e = 1'b1; branch_e = 1'b1; slti_e = 1'b0; stall_e = 1'b0;
        funct3_e = f3; br_less = less; br_equal = eq; pred_taken_e = pred; pc_e = pc;
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_brcnt"},  32'(branch_cnt),  32'(exp_br));
        chk({tag, "_miscnt"}, 32'(mispred_cnt), 32'(exp_mis));
    endtask

    function automatic int unsigned sat_inc(input int unsigned v);
        return (v == 15) ? 15 : v + 1;
    endfunction

    initial begin
        idle();
        pc_f = 32'h0; pc_e = 32'h0;
        rst_n = 1'b0;
        #12;
        chk("rst_pred", 32'(pred_taken_f), 32'd0);
        chk_cnt("rst");
        rst_n = 1'b1;
        tick();

        // BLTU mispredict at pc 0xC
        set_br(3'b110, 1'b1, 1'b0, 1'b0, 32'h0000_000C);
        #1;
        chk("bltu_un", 32'(br_un), 32'd1);
        chk("bltu_slti", 32'(slti_sel), 32'd0);
        chk("bltu_taken", 32'(taken_e), 32'd1);
        chk("bltu_redir", 32'(redirect), 32'd1);
        chk("bltu_ffd", 32'(flush_fd), 32'd1);
        chk("bltu_fde", 32'(flush_de), 32'd1);
        chk("bltu_tgt", 32'(redirect_tgt), 32'd1);
        tick();
        idle(); pc_f = 32'h0000_000C; exp_br = 1; exp_mis = 1;
        #1;
        chk("bltu_e3_pred", 32'(pred_taken_f), 32'd1);
        chk_cnt("bltu");

        // BNE equal=1, predicted taken -> not taken, redirect to pc+4
        set_br(3'b001, 1'b0, 1'b1, 1'b1, 32'h0000_0020);
        #1;
        chk("bne_taken", 32'(taken_e), 32'd0);
        chk("bne_redir", 32'(redirect), 32'd1);
        chk("bne_tgt", 32'(redirect_tgt), 32'd0);
        chk("bne_un", 32'(br_un), 32'd0);
        tick();
        exp_br = 2; exp_mis = 2;
        // BEQ equal=1, predicted taken -> correct, counts branch only
        set_br(3'b000, 1'b0, 1'b1, 1'b1, 32'h0000_0020);
        #1;
        chk("beq_taken", 32'(taken_e), 32'd1);
        chk("beq_redir", 32'(redirect), 32'd0);
        chk("beq_ffd", 32'(flush_fd), 32'd0);
        tick();
        idle(); pc_f = 32'h0000_0020; exp_br = 3;
        #1;
        chk_cnt("beq");
        chk("e8_pred", 32'(pred_taken_f), 32'd0);

        // Six taken BEQ at 0x40: entry 0 saturates at strong-taken
        pc_f = 32'h0000_0040;
        for (int i = 0; i < 6; i++) begin
            set_br(3'b000, 1'b0, 1'b1, 1'b1, 32'h0000_0040);
            tick();
            exp_br = sat_inc(exp_br);
        end
        idle(); #1;
        chk("sat_pred", 32'(pred_taken_f), 32'd1);
        chk_cnt("sat");
        set_br(3'b000, 1'b0, 1'b0, 1'b1, 32'h0000_0040);
        tick();
        idle(); exp_br = sat_inc(exp_br); exp_mis = sat_inc(exp_mis); #1;
        chk("sat_nt1_pred", 32'(pred_taken_f), 32'd1);
        set_br(3'b000, 1'b0, 1'b0, 1'b1, 32'h0000_0040);
        tick();
        idle(); exp_br = sat_inc(exp_br); exp_mis = sat_inc(exp_mis); #1;
        chk("sat_nt2_pred", 32'(pred_taken_f), 32'd0);
        chk_cnt("sat_nt");

        // Same-cycle lookup/update at 0x10: lookup sees pre-update state
        pc_f = 32'h0000_0010;
        set_br(3'b111, 1'b0, 1'b0, 1'b0, 32'h0000_0010);
        #1;
        chk("haz_pred_now", 32'(pred_taken_f), 32'd0);
        chk("bgeu_un", 32'(br_un), 32'd1);
        chk("bgeu_taken", 32'(taken_e), 32'd1);
        tick();
        idle(); exp_br = sat_inc(exp_br); exp_mis = sat_inc(exp_mis); #1;
        chk("haz_pred_next", 32'(pred_taken_f), 32'd1);

        // Stalled mispredicting BGE at 0x14
        pc_f = 32'h0000_0014;
        set_br(3'b101, 1'b0, 1'b0, 1'b0, 32'h0000_0014);
        stall_e = 1'b1;
        #1;
        chk("stall_taken", 32'(taken_e), 32'd1);
        chk("stall_redir", 32'(redirect), 32'd0);
        chk("stall_ffd", 32'(flush_fd), 32'd0);
        chk("stall_fde", 32'(flush_de), 32'd0);
        tick();
        idle(); #1;
        chk("stall_pred", 32'(pred_taken_f), 32'd0);
        chk_cnt("stall");

        // Bubble carrying a taken-looking BLT
        set_br(3'b100, 1'b1, 1'b0, 1'b0, 32'h0000_0014);
        valid_e = 1'b0;
        #1;
        chk("bub_taken", 32'(taken_e), 32'd0);
        chk("bub_redir", 32'(redirect), 32'd0);
        tick();
        idle(); #1;
        chk("bub_pred", 32'(pred_taken_f), 32'd0);
        chk_cnt("bub");

        // Comparator controls for SLTIU / SLTI and funct3 011 on a branch
        slti_e = 1'b1; funct3_e = 3'b011;
        #1;
        chk("sltiu_un", 32'(br_un), 32'd1);
        chk("sltiu_sel", 32'(slti_sel), 32'd1);
        funct3_e = 3'b010;
        #1;
        chk("slti_un", 32'(br_un), 32'd0);
        set_br(3'b011, 1'b1, 1'b1, 1'b0, 32'h0000_0030);
        #1;
        chk("f011_un", 32'(br_un), 32'd0);
        chk("f011_taken", 32'(taken_e), 32'd0);
        chk("f011_redir", 32'(redirect), 32'd0);
        tick();
        idle(); exp_br = sat_inc(exp_br); #1;
        chk_cnt("f011");

        // Drive both statistics counters into saturation
        for (int i = 0; i < 12; i++) begin
            set_br(3'b000, 1'b0, 1'b1, 1'b0, 32'h0000_0044);
            tick();
            exp_br = sat_inc(exp_br); exp_mis = sat_inc(exp_mis);
        end
        idle(); #1;
        chk_cnt("cntsat");
        chk("cntsat_br_max", 32'(branch_cnt), 32'd15);
        chk("cntsat_mis_max", 32'(mispred_cnt), 32'd15);

        // Train entry 3 to strong-taken, then reset mid-cycle with an update pending
        pc_f = 32'h0000_000C;
        set_br(3'b000, 1'b0, 1'b1, 1'b1, 32'h0000_000C);
        tick();
        set_br(3'b000, 1'b0, 1'b1, 1'b1, 32'h0000_000C);
        #2;
        rst_n = 1'b0;
        #1;
        exp_br = 0; exp_mis = 0;
        chk("arst_pred", 32'(pred_taken_f), 32'd0);
        chk("arst_taken", 32'(taken_e), 32'd1);
        chk_cnt("arst");
        tick();
        chk("arst_hold_pred", 32'(pred_taken_f), 32'd0);
        chk_cnt("arst_hold");
        idle();
        #2;
        rst_n = 1'b1;
        tick();
        set_br(3'b000, 1'b0, 1'b1, 1'b1, 32'h0000_000C);
        tick();
        idle(); exp_br = 1; #1;
        chk("post_rst_e3_pred", 32'(pred_taken_f), 32'd1);
        chk_cnt("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
